// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: store request channel, byte-serial memory write
// port, load hazard probe and status. The buffer sits on the slave modport.
interface store_buffer_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_mode;
    logic        st_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        ld_chk_en;
    logic [31:0] ld_chk_addr;
    logic [2:0]  ld_chk_mode;
    logic        ld_hazard;
    logic        empty;

    modport slave (
        input  st_valid, st_addr, st_data, st_mode,
        input  ld_chk_en, ld_chk_addr, ld_chk_mode,
        output st_ready, st_err, mem_we, mem_addr, mem_wdata, ld_hazard, empty
    );

    modport master (
        output st_valid, st_addr, st_data, st_mode,
        output ld_chk_en, ld_chk_addr, ld_chk_mode,
        input  st_ready, st_err, mem_we, mem_addr, mem_wdata, ld_hazard, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: queues SB/SH/SW stores in a small FIFO and drains them into
// the data memory one byte per clock, MSB first (big-endian). Loads that
// overlap any queued store (including a half-written head) raise ld_hazard.
module store_buffer #(
    parameter int DEPTH     = 4,
    parameter int MEM_BYTES = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  sb
);
    localparam int          PTR_W     = $clog2(DEPTH);
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

    // last holds n-1, so the final byte index of the entry
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  last;
    } entry_t;

    entry_t           fifo_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    state_t           state_r;
    logic [1:0]       byte_idx_r;
    logic             st_err_r;
    logic             mem_we_r;
    logic [31:0]      mem_addr_r;
    logic [7:0]       mem_wdata_r;

    logic        st_ready_s;
    logic        fire_s;
    logic        push_s;
    logic        bad_s;
    logic        pop_s;
    logic        stay_s;
    logic        hazard_s;
    logic        mode_ok_s;
    logic        range_ok_s;
    logic [32:0] st_end_s;
    entry_t      in_entry_s;
    entry_t      head_s;
    entry_t      next_s;

    // Store mode to last byte index; illegal codes are filtered separately.
    function automatic logic [1:0] store_last(input logic [2:0] mode);
        case (mode)
            3'b000:  store_last = 2'd0;
            3'b001:  store_last = 2'd1;
            default: store_last = 2'd3;
        endcase
    endfunction

    // Load mode to byte count; unknown codes are treated as a full word.
    function automatic logic [2:0] load_len(input logic [2:0] mode);
        case (mode)
            3'b000, 3'b011: load_len = 3'd1;
            3'b001, 3'b100: load_len = 3'd2;
            default:        load_len = 3'd4;
        endcase
    endfunction

    // Byte idx of a right-aligned value, counted from its most significant byte.
    function automatic logic [7:0] pick_byte(input logic [31:0] data,
                                             input logic [1:0]  last,
                                             input logic [1:0]  idx);
        logic [1:0] sel;
        sel       = last - idx;
        pick_byte = data[{sel, 3'b000} +: 8];
    endfunction

    // Half-open byte ranges [a, a+alen) and [b, b+blen), evaluated without wrap.
    function automatic logic ranges_overlap(input logic [31:0] a, input logic [2:0] alen,
                                            input logic [31:0] b, input logic [2:0] blen);
        logic [32:0] a_end;
        logic [32:0] b_end;
        a_end          = {1'b0, a} + 33'(alen);
        b_end          = {1'b0, b} + 33'(blen);
        ranges_overlap = ({1'b0, a} < b_end) && ({1'b0, b} < a_end);
    endfunction

    // Request decode: handshake, legality and the push/pop decisions.
    always_comb begin
        st_ready_s = (count_r != FULL_CNT);
        fire_s     = sb.st_valid && st_ready_s;
        mode_ok_s  = (sb.st_mode <= 3'b010);
        st_end_s   = {1'b0, sb.st_addr} + 33'(store_last(sb.st_mode));
        range_ok_s = (st_end_s < MEM_LIMIT);
        push_s     = fire_s && mode_ok_s && range_ok_s;
        bad_s      = fire_s && !(mode_ok_s && range_ok_s);
        in_entry_s = '{addr: sb.st_addr, data: sb.st_data, last: store_last(sb.st_mode)};
        head_s     = fifo_r[rd_ptr_r];
        pop_s      = (state_r == WRITE) && (byte_idx_r == head_s.last);
        // After a pop the next head is the second slot, or the entry pushed this edge.
        if (count_r > (PTR_W+1)'(1)) begin
            next_s = fifo_r[rd_ptr_r + PTR_W'(1)];
        end else begin
            next_s = in_entry_s;
        end
        stay_s = (count_r > (PTR_W+1)'(1)) || push_s;
    end

    // Load hazard: overlap against every occupied slot, head included.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset = PTR_W'(i) - rd_ptr_r;
            if (({1'b0, offset} < count_r) &&
                ranges_overlap(fifo_r[i].addr, {1'b0, fifo_r[i].last} + 3'd1,
                               sb.ld_chk_addr, load_len(sb.ld_chk_mode))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        hazard_s = hazard_s && sb.ld_chk_en;
    end

    // FIFO payload storage; contents are only meaningful under count_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= in_entry_s;
        end
    end

    // FIFO pointers, occupancy and the one-cycle error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            st_err_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
            st_err_r <= bad_s;
        end
    end

    // Drain FSM: the write port registers are loaded with the byte that the
    // memory will capture at the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            byte_idx_r  <= 2'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (count_r != '0) begin
                        state_r     <= WRITE;
                        byte_idx_r  <= 2'd0;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= head_s.addr;
                        mem_wdata_r <= pick_byte(head_s.data, head_s.last, 2'd0);
                    end else begin
                        mem_we_r <= 1'b0;
                    end
                end
                WRITE: begin
                    if (pop_s && stay_s) begin
                        byte_idx_r  <= 2'd0;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= next_s.addr;
                        mem_wdata_r <= pick_byte(next_s.data, next_s.last, 2'd0);
                    end else if (pop_s) begin
                        state_r    <= IDLE;
                        byte_idx_r <= 2'd0;
                        mem_we_r   <= 1'b0;
                    end else begin
                        byte_idx_r  <= byte_idx_r + 2'd1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= head_s.addr + 32'(byte_idx_r + 2'd1);
                        mem_wdata_r <= pick_byte(head_s.data, head_s.last, byte_idx_r + 2'd1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    byte_idx_r <= 2'd0;
                    mem_we_r   <= 1'b0;
                end
            endcase
        end
    end

    assign sb.st_ready  = st_ready_s;
    assign sb.st_err    = st_err_r;
    assign sb.mem_we    = mem_we_r;
    assign sb.mem_addr  = mem_addr_r;
    assign sb.mem_wdata = mem_wdata_r;
    assign sb.ld_hazard = hazard_s;
    assign sb.empty     = (count_r == '0) && (state_r == IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a transaction-level model schedules every byte
// write at the cycle the drain timing rules demand, and a compare process
// checks all outputs each cycle; directed tests add literal memory checks.
module tb_store_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if sb ();
    store_buffer #(.DEPTH(4), .MEM_BYTES(1000)) dut (.clk(clk), .rst_n(rst_n), .sb(sb));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory seen by the write port
    logic [7:0] mem [1000];
    initial begin
        for (int i = 0; i < 1000; i++) mem[i] = 8'hEE;
    end
    always @(posedge clk) begin
        if (sb.mem_we === 1'b1 && sb.mem_addr < 32'd1000) mem[sb.mem_addr] <= sb.mem_wdata;
    end

    // ---------------- model ----------------
    typedef struct { int t; logic [31:0] a; logic [7:0] d; } wr_t;
    typedef struct { longint a; int n; int pop; } ent_t;
    wr_t  sched [$];
    ent_t ents  [$];
    int   cur      = 0;
    int   last_t   = -100;
    int   err_edge = -100;

    function automatic int st_len(input logic [2:0] m);
        case (m)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int ld_len(input logic [2:0] m);
        case (m)
            3'b000, 3'b011: return 1;
            3'b001, 3'b100: return 2;
            default:        return 4;
        endcase
    endfunction

    always @(negedge rst_n) begin
        sched.delete(); ents.delete(); last_t = -100; err_edge = -100;
    end

    always @(posedge clk) begin
        int vc, n, t0;
        longint a;
        vc = 0;
        foreach (ents[i]) if (ents[i].pop > cur) vc++;
        cur = cur + 1;
        if (!rst_n) begin
            sched.delete(); ents.delete(); last_t = -100; err_edge = -100;
        end else begin
            if (sb.st_valid === 1'b1 && vc < 4) begin
                n = st_len(sb.st_mode);
                a = longint'(sb.st_addr);
                if (n != 0 && a + n - 1 < 1000) begin
                    t0 = (last_t >= cur) ? last_t + 1 : cur + 2;
                    for (int k = 0; k < n; k++)
                        sched.push_back('{t0 + k, sb.st_addr + 32'(k), 8'(sb.st_data >> (8 * (n - 1 - k)))});
                    last_t = t0 + n - 1;
                    ents.push_back('{a, n, last_t});
                end else begin
                    err_edge = cur;
                end
            end
            while (sched.size() > 0 && sched[0].t <= cur) void'(sched.pop_front());
            while (ents.size() > 0 && ents[0].pop <= cur) void'(ents.pop_front());
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int vc;
        logic exp_we, exp_hz;
        longint la, lm;
        vc = 0; exp_hz = 1'b0;
        la = longint'(sb.ld_chk_addr); lm = longint'(ld_len(sb.ld_chk_mode));
        foreach (ents[i]) begin
            if (ents[i].pop > cur) begin
                vc++;
                if (ents[i].a < la + lm && la < ents[i].a + ents[i].n) exp_hz = 1'b1;
            end
        end
        exp_hz = exp_hz && (sb.ld_chk_en === 1'b1);
        exp_we = rst_n && sched.size() > 0 && sched[0].t == cur + 1;
        check("mem_we", sb.mem_we, exp_we);
        if (exp_we) begin
            check("mem_addr", sb.mem_addr, sched[0].a);
            check("mem_wdata", sb.mem_wdata, sched[0].d);
        end
        check("st_ready", sb.st_ready, vc < 4);
        check("empty", sb.empty, vc == 0);
        check("st_err", sb.st_err, rst_n && err_edge == cur);
        check("ld_hazard", sb.ld_hazard, exp_hz);
    end

    // ---------------- stimulus ----------------
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                         output int waited);
        logic rdy;
        sb.st_valid = 1'b1; sb.st_addr = a; sb.st_data = d; sb.st_mode = m;
        waited = 0;
        do begin
            @(negedge clk); rdy = sb.st_ready;
            @(posedge clk); waited++;
        end while (!rdy && waited < 64);
        check("store_accept", rdy, 1'b1);
        #1 sb.st_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (sb.empty !== 1'b1 && n < 200);
        check("drain_done", sb.empty, 1'b1);
        @(posedge clk); #1;
    endtask

    logic [31:0] words [5] = '{32'h01020304, 32'h11121314, 32'h21222324, 32'h31323334, 32'h41424344};

    initial begin
        int w;
        sb.st_valid = 1'b0; sb.st_addr = 32'd0; sb.st_data = 32'd0; sb.st_mode = 3'b000;
        sb.ld_chk_en = 1'b0; sb.ld_chk_addr = 32'd0; sb.ld_chk_mode = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", sb.mem_we, 1'b0);
        check("rst_mem_addr", sb.mem_addr, 32'd0);
        check("rst_mem_wdata", sb.mem_wdata, 8'd0);
        check("rst_empty", sb.empty, 1'b1);
        check("rst_ready", sb.st_ready, 1'b1);
        check("rst_err", sb.st_err, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: SW into empty buffer, first byte presented after E1
        store(32'h10, 32'hAABBCCDD, 3'b010, w);
        @(negedge clk);
        check("t1_e0_we", sb.mem_we, 1'b0);
        check("t1_e0_empty", sb.empty, 1'b0);
        @(negedge clk);
        check("t1_e1_we", sb.mem_we, 1'b1);
        check("t1_e1_addr", sb.mem_addr, 32'h10);
        check("t1_e1_data", sb.mem_wdata, 8'hAA);
        wait_empty();
        check("t1_m10", mem[16], 8'hAA);
        check("t1_m11", mem[17], 8'hBB);
        check("t1_m12", mem[18], 8'hCC);
        check("t1_m13", mem[19], 8'hDD);

        // 2: SB then SH back-to-back
        store(32'h20, 32'h123, 3'b000, w);
        store(32'h22, 32'hBEEF, 3'b001, w);
        wait_empty();
        check("t2_m20", mem[32], 8'h23);
        check("t2_m21", mem[33], 8'hEE);
        check("t2_m22", mem[34], 8'hBE);
        check("t2_m23", mem[35], 8'hEF);

        // 3: fill the FIFO while draining; 5th store stalls
        for (int i = 0; i < 5; i++) begin
            store(32'h100 + 32'(4 * i), words[i], 3'b010, w);
            if (i == 3) check("t3_4th_wait", w, 1);
            if (i == 4) check("t3_5th_wait", w, 3);
        end
        wait_empty();
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 4; k++)
                check("t3_mem", mem[256 + 4 * i + k], 8'(words[i] >> (8 * (3 - k))));

        // 4: illegal and boundary stores
        store(32'd999, 32'hBEEF, 3'b001, w);
        @(negedge clk); check("t4_sh999_err", sb.st_err, 1'b1);
        store(32'h30, 32'h55, 3'b011, w);
        @(negedge clk); check("t4_mode3_err", sb.st_err, 1'b1);
        store(32'hFFFFFFFF, 32'h77, 3'b000, w);
        @(negedge clk); check("t4_wrap_err", sb.st_err, 1'b1);
        store(32'd997, 32'h12345678, 3'b010, w);
        @(negedge clk); check("t4_sw997_err", sb.st_err, 1'b1);
        store(32'd999, 32'hA5, 3'b000, w);
        @(negedge clk); check("t4_sb999_ok", sb.st_err, 1'b0);
        store(32'd996, 32'hC0C1C2C3, 3'b010, w);
        wait_empty();
        check("t4_m30", mem[48], 8'hEE);
        check("t4_m996", mem[996], 8'hC0);
        check("t4_m999", mem[999], 8'hC3);

        // 5: load hazard against a pending SW
        store(32'h40, 32'hDEADBEEF, 3'b010, w);
        sb.ld_chk_en = 1'b1; sb.ld_chk_addr = 32'h42; sb.ld_chk_mode = 3'b001;
        @(negedge clk); check("t5_hz42", sb.ld_hazard, 1'b1);
        #1 sb.ld_chk_addr = 32'h44;
        #1 check("t5_hz44", sb.ld_hazard, 1'b0);
        sb.ld_chk_addr = 32'h3F; sb.ld_chk_mode = 3'b010;
        #1 check("t5_hz3f", sb.ld_hazard, 1'b1);
        sb.ld_chk_addr = 32'h42; sb.ld_chk_mode = 3'b001;
        wait_empty();
        @(negedge clk); check("t5_hz_after", sb.ld_hazard, 1'b0);
        sb.ld_chk_en = 1'b0;
        @(posedge clk); #1;

        // 6: reset after the second byte of an SW
        store(32'h60, 32'h11223344, 3'b010, w);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_we", sb.mem_we, 1'b0);
        check("t6_empty", sb.empty, 1'b1);
        check("t6_ready", sb.st_ready, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t6_m60", mem[96], 8'h11);
        check("t6_m61", mem[97], 8'h22);
        check("t6_m62", mem[98], 8'hEE);
        check("t6_m63", mem[99], 8'hEE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
